testio_target: RTL and testbench



---
 rtl/testio_target.sv | 278 +++++++++++++++++++++++++++
 tb/tb_testio_target.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testio_target.sv
// Responder end of the testio serial link: deserialises host frames, masters the
// on-chip bus and serialises the reply. Optional bus timeout: TESTIO_TARGET_TIMEOUT_EN.
module testio_target #(
    parameter int DATA_W      = 32,
    parameter int MASK_W      = 4,
    parameter int TI_W        = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              ti_clk,
    input  logic              ti_rstn,
    input  logic [TI_W-1:0]   ti_din,
    output logic [TI_W-1:0]   ti_dout,
    output logic [TI_W-1:0]   ti_doen,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_type,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    output logic [MASK_W-1:0] req_strb,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              resp_err,
    output logic              frame_err
);

    if (TI_W != 1) begin : g_ti_w_check
        $error("testio_target: TI_W must be 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("testio_target: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, RX_TYPE, RX_ADDR, RX_STRB, RX_DATA, RX_PARITY, RX_STOP,
        BUS_REQ, BUS_WAIT, TURN, TX_START, TX_ACK, TX_DATA, TX_PARITY, TX_STOP
    } state_t;

    localparam logic [7:0] WORD_LEN = 8'(DATA_W - 1);
    localparam logic [7:0] MASK_LEN = 8'(MASK_W - 1);

    state_t              state_reg, state_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic                rx_par_reg, rx_par_next;
    logic                par_err_reg, par_err_next;
    logic                type_reg, type_next;
    logic [DATA_W-1:0]   addr_reg, addr_next;
    logic [MASK_W-1:0]   strb_reg, strb_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                ack_reg, ack_next;
    logic [DATA_W-1:0]   tx_sh_reg, tx_sh_next;
    logic                tx_par_reg, tx_par_next;
    logic                dout_reg, dout_next;
    logic                doen_reg, doen_next;
    logic                frame_err_reg, frame_err_next;
    logic                din;
    logic                timeout_hit;

    assign din = ti_din[0];

`ifdef TESTIO_TARGET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_reg;

    // Free-running while a bus transaction is outstanding, cleared elsewhere.
    always_ff @(posedge ti_clk) begin
        if (!ti_rstn) begin
            to_cnt_reg <= '0;
        end else if (state_reg == BUS_REQ || state_reg == BUS_WAIT) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end else begin
            to_cnt_reg <= '0;
        end
    end
    assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rx_par_next    = rx_par_reg;
        par_err_next   = par_err_reg;
        type_next      = type_reg;
        addr_next      = addr_reg;
        strb_next      = strb_reg;
        data_next      = data_reg;
        ack_next       = ack_reg;
        tx_sh_next     = tx_sh_reg;
        tx_par_next    = tx_par_reg;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!din) begin
                    state_next   = RX_TYPE;
                    rx_par_next  = 1'b0;
                    par_err_next = 1'b0;
                    ack_next     = 1'b0;
                end
            end
            RX_TYPE: begin
                type_next   = din;
                rx_par_next = din;
                cnt_next    = WORD_LEN;
                state_next  = RX_ADDR;
            end
            RX_ADDR: begin
                addr_next   = {addr_reg[DATA_W-2:0], din};
                rx_par_next = rx_par_reg ^ din;
                if (cnt_reg == 8'd0) begin
                    if (type_reg) begin
                        cnt_next   = MASK_LEN;
                        state_next = RX_STRB;
                    end else begin
                        state_next = RX_PARITY;
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            RX_STRB: begin
                strb_next   = {strb_reg[MASK_W-2:0], din};
                rx_par_next = rx_par_reg ^ din;
                if (cnt_reg == 8'd0) begin
                    cnt_next   = WORD_LEN;
                    state_next = RX_DATA;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            RX_DATA: begin
                data_next   = {data_reg[DATA_W-2:0], din};
                rx_par_next = rx_par_reg ^ din;
                if (cnt_reg == 8'd0) begin
                    state_next = RX_PARITY;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            RX_PARITY: begin
                par_err_next = din ^ rx_par_reg;
                state_next   = RX_STOP;
            end
            RX_STOP: begin
                if (!din) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else if (par_err_reg) begin
                    ack_next   = 1'b1;
                    state_next = TURN;
                end else begin
                    state_next = BUS_REQ;
                end
            end
            BUS_REQ: begin
                // A response arriving together with the handshake is not looked at here.
                if (req_ready) begin
                    state_next = BUS_WAIT;
                end else if (timeout_hit) begin
                    ack_next   = 1'b1;
                    state_next = TURN;
                end
            end
            BUS_WAIT: begin
                if (resp_valid) begin
                    ack_next    = resp_err;
                    tx_sh_next  = resp_data;
                    tx_par_next = ^resp_data;
                    state_next  = TURN;
                end else if (timeout_hit) begin
                    ack_next   = 1'b1;
                    state_next = TURN;
                end
            end
            TURN:     state_next = TX_START;
            TX_START: state_next = TX_ACK;
            TX_ACK: begin
                if (!ack_reg && !type_reg) begin
                    cnt_next   = WORD_LEN;
                    state_next = TX_DATA;
                end else begin
                    state_next = TX_STOP;
                end
            end
            TX_DATA: begin
                tx_sh_next = {tx_sh_reg[DATA_W-2:0], 1'b0};
                if (cnt_reg == 8'd0) begin
                    state_next = TX_PARITY;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            TX_PARITY: state_next = TX_STOP;
            TX_STOP:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Pad outputs are registered from the state being entered, so each TX state
    // drives its own bit during the cycle it occupies.
    always_comb begin
        dout_next = 1'b1;
        doen_next = 1'b1;
        case (state_next)
            TX_START: begin
                dout_next = 1'b0;
                doen_next = 1'b0;
            end
            TX_ACK: begin
                dout_next = ack_next;
                doen_next = 1'b0;
            end
            TX_DATA: begin
                dout_next = tx_sh_next[DATA_W-1];
                doen_next = 1'b0;
            end
            TX_PARITY: begin
                dout_next = tx_par_reg;
                doen_next = 1'b0;
            end
            TX_STOP: begin
                dout_next = 1'b1;
                doen_next = 1'b0;
            end
            default: begin
                dout_next = 1'b1;
                doen_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ti_clk) begin
        if (!ti_rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rx_par_reg    <= 1'b0;
            par_err_reg   <= 1'b0;
            type_reg      <= 1'b0;
            addr_reg      <= '0;
            strb_reg      <= '0;
            data_reg      <= '0;
            ack_reg       <= 1'b0;
            tx_sh_reg     <= '0;
            tx_par_reg    <= 1'b0;
            dout_reg      <= 1'b1;
            doen_reg      <= 1'b1;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rx_par_reg    <= rx_par_next;
            par_err_reg   <= par_err_next;
            type_reg      <= type_next;
            addr_reg      <= addr_next;
            strb_reg      <= strb_next;
            data_reg      <= data_next;
            ack_reg       <= ack_next;
            tx_sh_reg     <= tx_sh_next;
            tx_par_reg    <= tx_par_next;
            dout_reg      <= dout_next;
            doen_reg      <= doen_next;
            frame_err_reg <= frame_err_next;
        end
    end

    for (genvar gi = 0; gi < TI_W; gi++) begin : g_lane
        assign ti_dout[gi] = dout_reg;
        assign ti_doen[gi] = doen_reg;
    end

    assign req_valid = (state_reg == BUS_REQ);
    assign req_type  = type_reg;
    assign req_addr  = addr_reg;
    assign req_data  = data_reg;
    assign req_strb  = type_reg ? strb_reg : {MASK_W{1'b1}};
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_testio_target.sv
// Bench for testio_target: directed and random frames against a frame-level model
// of the host link and bus; TESTIO_TARGET_TIMEOUT_EN adds the timeout case.
module tb_testio_target;
    localparam int DATA_W      = 32;
    localparam int MASK_W      = 4;
    localparam int TI_W        = 1;
    localparam int TIMEOUT_CYC = 255;

    logic              ti_clk = 1'b0;
    logic              ti_rstn;
    logic [TI_W-1:0]   ti_din;
    logic [TI_W-1:0]   ti_dout;
    logic [TI_W-1:0]   ti_doen;
    logic              req_valid;
    logic              req_ready;
    logic              req_type;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [MASK_W-1:0] req_strb;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              frame_err;

    int checks = 0;
    int errors = 0;
    bit frame_q[$];

    testio_target #(
        .DATA_W(DATA_W), .MASK_W(MASK_W), .TI_W(TI_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .ti_clk(ti_clk), .ti_rstn(ti_rstn), .ti_din(ti_din), .ti_dout(ti_dout),
        .ti_doen(ti_doen), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .req_strb(req_strb), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .frame_err(frame_err)
    );

    always #5 ti_clk = ~ti_clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Host frame built field by field: START, TYPE, ADDR, [STRB, DATA], PARITY, STOP.
    task automatic build_frame(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] data, input bit flip_par, input bit bad_stop);
        bit par;
        frame_q.delete();
        frame_q.push_back(1'b0);
        frame_q.push_back(wr);
        par = wr;
        for (int i = 31; i >= 0; i--) begin frame_q.push_back(addr[i]); par ^= addr[i]; end
        if (wr) begin
            for (int i = 3; i >= 0; i--) begin frame_q.push_back(strb[i]); par ^= strb[i]; end
            for (int i = 31; i >= 0; i--) begin frame_q.push_back(data[i]); par ^= data[i]; end
        end
        frame_q.push_back(par ^ flip_par);
        frame_q.push_back(!bad_stop);
    endtask

    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] data,
                           input bit flip_par, input bit bad_stop,
                           input logic [31:0] rdata, input bit rerr,
                           input int rdy_dly, input int rsp_dly, input bit junk);
        bit exp_q[$];
        bit got_q[$];
        bit exp_req, timeout_exp, done, prev_doen, seen_v, stable_ok, stray_done;
        int idx, hs, fe, segs, vcycles, first_low, after, budget, phase, wait_cnt;
        int hs_cyc, resp_cyc, stop_cyc, last_v, trigger;
        logic h_type, s_type;
        logic [31:0] h_addr, h_data, s_addr, s_data;
        logic [3:0] h_strb, s_strb;
        logic [63:0] gv, ev;

        exp_req     = !bad_stop && !flip_par;
        timeout_exp = exp_req && (rdy_dly < 0);
        build_frame(wr, addr, strb, data, flip_par, bad_stop);
        if (!bad_stop) begin
            exp_q.push_back(1'b0);
            if (flip_par || timeout_exp || rerr) begin
                exp_q.push_back(1'b1);
            end else begin
                exp_q.push_back(1'b0);
                if (!wr) begin
                    for (int i = 31; i >= 0; i--) exp_q.push_back(rdata[i]);
                    exp_q.push_back(^rdata);
                end
            end
            exp_q.push_back(1'b1);
        end

        done = 0; prev_doen = 1; seen_v = 0; stable_ok = 1; stray_done = 0;
        hs = 0; fe = 0; segs = 0; vcycles = 0; first_low = -1; after = 0; phase = 0;
        wait_cnt = 0; hs_cyc = -1; resp_cyc = -1; stop_cyc = -1; last_v = -1;
        h_type = 0; h_addr = 0; h_data = 0; h_strb = 0;
        s_type = 0; s_addr = 0; s_data = 0; s_strb = 0;
        budget = frame_q.size() + ((rdy_dly < 0) ? TIMEOUT_CYC + 20 : rdy_dly) + rsp_dly + 80;

        ti_din = frame_q[0];
        idx = 1;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge ti_clk);
            if (frame_err) fe++;
            if (!ti_doen[0]) begin
                if (prev_doen) segs++;
                if (first_low < 0) first_low = cyc;
                got_q.push_back(ti_dout[0]);
            end
            if (req_valid) vcycles++;
            prev_doen = ti_doen[0];
            if (exp_q.size() > 0 && got_q.size() >= exp_q.size() && ti_doen[0]) done = 1;
            if (exp_q.size() == 0 && idx >= frame_q.size()) begin
                after++;
                if (after > 6) done = 1;
            end

            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_data  = $urandom;
            resp_err   = 1'($urandom);
            if (phase == 0) begin
                if (req_valid) begin
                    if (!seen_v) begin
                        seen_v = 1;
                        s_type = req_type; s_addr = req_addr; s_data = req_data; s_strb = req_strb;
                    end else if ({req_type, req_addr, req_data, req_strb} !== {s_type, s_addr, s_data, s_strb}) begin
                        stable_ok = 0;
                    end
                    last_v = cyc;
                    if (rdy_dly >= 0 && wait_cnt >= rdy_dly) begin
                        req_ready = 1'b1;
                        hs++;
                        h_type = req_type; h_addr = req_addr; h_data = req_data; h_strb = req_strb;
                        hs_cyc = cyc;
                        phase = 1;
                        if (junk) begin
                            resp_valid = 1'b1;
                            resp_data  = ~rdata;
                            resp_err   = ~rerr;
                        end
                    end
                    wait_cnt++;
                end else if (seen_v && rdy_dly < 0 && !stray_done) begin
                    stray_done = 1;
                    resp_valid = 1'b1;
                    resp_err   = 1'b0;
                    resp_data  = rdata;
                end
            end else if (phase == 1 && (cyc - hs_cyc) >= rsp_dly) begin
                resp_valid = 1'b1;
                resp_data  = rdata;
                resp_err   = rerr;
                resp_cyc   = cyc;
                phase      = 2;
            end

            if (done) begin
                ti_din = 1'b1;
            end else if (idx < frame_q.size()) begin
                if (idx == frame_q.size() - 1) stop_cyc = cyc;
                ti_din = frame_q[idx];
                idx++;
            end else if (exp_q.size() > 0) begin
                ti_din = 1'($urandom_range(0, 1));
            end else begin
                ti_din = 1'b1;
            end
        end
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        chk({name, ":completed"}, 64'(done), 64'(1));
        chk({name, ":req_count"}, 64'(hs), 64'((exp_req && !timeout_exp) ? 1 : 0));
        if (hs > 0) begin
            chk({name, ":req_type"}, 64'(h_type), 64'(wr));
            chk({name, ":req_addr"}, 64'(h_addr), 64'(addr));
            chk({name, ":req_strb"}, 64'(h_strb), 64'(wr ? strb : 4'hF));
            if (wr) chk({name, ":req_data"}, 64'(h_data), 64'(data));
            chk({name, ":req_stable"}, 64'(stable_ok), 64'(1));
        end
        if (timeout_exp) chk({name, ":valid_cycles"}, 64'(vcycles), 64'(TIMEOUT_CYC));
        chk({name, ":frame_err"}, 64'(fe), 64'(bad_stop ? 1 : 0));
        chk({name, ":resp_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        gv = '0;
        ev = '0;
        foreach (got_q[i]) gv = {gv[62:0], got_q[i]};
        foreach (exp_q[i]) ev = {ev[62:0], exp_q[i]};
        chk({name, ":resp_bits"}, gv, ev);
        chk({name, ":doen_segments"}, 64'(segs), 64'((exp_q.size() > 0) ? 1 : 0));
        if (exp_q.size() > 0) begin
            trigger = flip_par ? stop_cyc : (timeout_exp ? last_v : resp_cyc);
            chk({name, ":turn_latency"}, 64'(first_low - trigger), 64'(2));
        end
        $display("txn %s wr=%0d addr=%h exp_bits=%0d got_bits=%0d req=%0d frame_err=%0d",
                 name, wr, addr, exp_q.size(), got_q.size(), hs, fe);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ":dout"}, 64'(ti_dout), 64'(1));
        chk({name, ":doen"}, 64'(ti_doen), 64'(1));
        chk({name, ":req_valid"}, 64'(req_valid), 64'(0));
        chk({name, ":frame_err"}, 64'(frame_err), 64'(0));
    endtask

    task automatic quiet_window(input string name, input int n);
        int drv;
        drv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge ti_clk);
            ti_din = 1'b1;
            if (!ti_doen[0] || req_valid) drv++;
        end
        chk({name, ":quiet"}, 64'(drv), 64'(0));
        $display("txn %s quiet_cycles=%0d activity=%0d", name, n, drv);
    endtask

    initial begin
        logic [31:0] r_addr, r_data, r_rdata;
        logic [3:0]  r_strb;
        bit          r_wr, r_flip, r_bad, r_err, r_junk, seen;
        int          r_gap;

        ti_rstn = 1'b0; ti_din = 1'b1; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_err = 1'b0;
        repeat (3) @(negedge ti_clk);
        check_reset_outputs("reset");
        $display("txn reset dout=%0d doen=%0d req_valid=%0d", ti_dout, ti_doen, req_valid);
        ti_rstn = 1'b1;
        @(negedge ti_clk);

        run_txn("wr_basic", 1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0, 1, 0);
        run_txn("rd_basic", 0, 32'h0000_0004, 4'h0, 32'h0, 0, 0, 32'hA5A5_0001, 0, 1, 2, 0);
        run_txn("wr_par_err", 1, 32'h0000_0040, 4'h5, 32'h0F0F_0F0F, 1, 0, 32'h0, 0, 0, 1, 0);
        run_txn("rd_bad_stop", 0, 32'h0000_0008, 4'h0, 32'h0, 0, 1, 32'h0, 0, 0, 1, 0);
        run_txn("rd_bus_err", 0, 32'h0000_0010, 4'h0, 32'h0, 0, 0, 32'h1234_5678, 1, 2, 3, 1);
        run_txn("wr_junk_hs", 1, 32'hFFFF_FFFC, 4'h1, 32'h8000_0001, 0, 0, 32'h0, 0, 3, 1, 1);

        // Reset while the 10th data bit of a write is on the wire.
        build_frame(1, 32'h0000_2000, 4'h3, 32'h1234_5678, 0, 0);
        ti_din = frame_q[0];
        for (int i = 1; i <= 47; i++) begin
            @(negedge ti_clk);
            ti_din = frame_q[i];
            if (i == 47) ti_rstn = 1'b0;
        end
        repeat (2) @(negedge ti_clk);
        ti_din = 1'b1;
        check_reset_outputs("rst_rx");
        ti_rstn = 1'b1;
        quiet_window("rst_rx_after", 8);
        run_txn("rd_after_rst", 0, 32'h0000_0020, 4'h0, 32'h0, 0, 0, 32'hC001_D00D, 0, 0, 1, 0);

        // Reset while the bus request is pending.
        build_frame(1, 32'h0000_3000, 4'hC, 32'hCAFE_F00D, 0, 0);
        ti_din = frame_q[0];
        for (int i = 1; i < frame_q.size(); i++) begin
            @(negedge ti_clk);
            ti_din = frame_q[i];
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge ti_clk);
            ti_din = 1'b1;
            if (req_valid) seen = 1;
        end
        chk("rst_bus:req_seen", 64'(seen), 64'(1));
        ti_rstn = 1'b0;
        @(negedge ti_clk);
        check_reset_outputs("rst_bus");
        ti_rstn = 1'b1;
        quiet_window("rst_bus_after", 8);
        run_txn("wr_after_rst", 1, 32'h0000_3004, 4'hA, 32'h5555_AAAA, 0, 0, 32'h0, 0, 1, 1, 0);

`ifdef TESTIO_TARGET_TIMEOUT_EN
        run_txn("wr_timeout", 1, 32'h0000_4000, 4'hF, 32'h0BAD_CAFE, 0, 0, 32'h0, 0, -1, 1, 0);
        run_txn("rd_after_to", 0, 32'h0000_4004, 4'h0, 32'h0, 0, 0, 32'h7777_0000, 0, 0, 1, 0);
`endif

        for (int t = 0; t < 24; t++) begin
            r_wr    = 1'($urandom);
            r_addr  = $urandom;
            r_data  = $urandom;
            r_strb  = 4'($urandom);
            r_rdata = $urandom;
            r_flip  = ($urandom_range(0, 7) == 0);
            r_bad   = !r_flip && ($urandom_range(0, 7) == 0);
            r_err   = ($urandom_range(0, 3) == 0);
            r_junk  = 1'($urandom);
            run_txn($sformatf("rnd%0d", t), r_wr, r_addr, r_strb, r_data, r_flip, r_bad,
                    r_rdata, r_err, $urandom_range(0, 4), $urandom_range(1, 4), r_junk);
            r_gap = $urandom_range(0, 3);
            for (int g = 0; g < r_gap; g++) begin
                @(negedge ti_clk);
                ti_din = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
